// File: rtl/wash_countdown_pkg.sv
// Shared definitions for the wash countdown and its display path:
// state codes, default phase durations and a binary-to-BCD helper.
package wash_countdown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WASH  = 3'd1;
  localparam logic [2:0] ST_RINSE = 3'd2;
  localparam logic [2:0] ST_SPIN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned DEF_TICK_DIV = 100000000;
  localparam int unsigned DEF_WASH_S   = 30;
  localparam int unsigned DEF_RINSE_S  = 20;
  localparam int unsigned DEF_SPIN_S   = 15;

  // Two BCD digits {tens, units} for a value in 0..99.
  function automatic logic [7:0] bcd2(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/wash_countdown_bcd2.sv
// Two-digit BCD register with synchronous load and single-step decrement.
module bcd2_down_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       is_one
);

  logic [3:0] tens_reg;
  logic [3:0] units_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_reg  <= 4'd0;
      units_reg <= 4'd0;
    end else if (load) begin
      tens_reg  <= load_val[7:4];
      units_reg <= load_val[3:0];
    end else if (dec) begin
      // Borrow from tens when units is already zero (10 -> 09).
      if (units_reg != 4'd0) begin
        units_reg <= units_reg - 4'd1;
      end else begin
        units_reg <= 4'd9;
        tens_reg  <= tens_reg - 4'd1;
      end
    end
  end

  assign tens   = tens_reg;
  assign units  = units_reg;
  assign is_one = (tens_reg == 4'd0) && (units_reg == 4'd1);

endmodule

// File: rtl/wash_countdown.sv
// Washing-machine program sequencer: WASH -> RINSE -> SPIN -> DONE, with a
// 1 s prescaler and a two-digit BCD seconds display.
module wash_countdown
  import wash_countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned WASH_S   = DEF_WASH_S,
  parameter int unsigned RINSE_S  = DEF_RINSE_S,
  parameter int unsigned SPIN_S   = DEF_SPIN_S
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [2:0] phase,
  output logic       busy,
  output logic       done
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [7:0]  WASH_BCD  = bcd2(WASH_S);
  localparam logic [7:0]  RINSE_BCD = bcd2(RINSE_S);
  localparam logic [7:0]  SPIN_BCD  = bcd2(SPIN_S);

  logic [2:0]  state_reg, state_next;
  logic [31:0] presc_reg, presc_next;
  logic        start_reg;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic        start_edge;
  logic        tick;
  logic        cnt_load;
  logic        cnt_dec;
  logic [7:0]  load_val;
  logic        is_one;

  assign start_edge = start && !start_reg;
  assign tick       = (presc_reg == TICK_LAST);

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    load_val   = 8'h00;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_next = ST_WASH;
          cnt_load   = 1'b1;
          load_val   = WASH_BCD;
          presc_next = 32'd0;
        end
      end
      ST_WASH, ST_RINSE, ST_SPIN: begin
        // Pause freezes prescaler, digits and state alike.
        if (!pause) begin
          presc_next = tick ? 32'd0 : presc_reg + 32'd1;
          if (tick) begin
            if (is_one) begin
              cnt_load = 1'b1;
              case (state_reg)
                ST_WASH: begin
                  state_next = ST_RINSE;
                  load_val   = RINSE_BCD;
                end
                ST_RINSE: begin
                  state_next = ST_SPIN;
                  load_val   = SPIN_BCD;
                end
                default: begin
                  state_next = ST_DONE;
                  load_val   = 8'h00;
                  done_next  = 1'b1;
                end
              endcase
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next == ST_WASH) || (state_next == ST_RINSE) ||
                (state_next == ST_SPIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      presc_reg <= 32'd0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      start_reg <= start;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  bcd2_down_counter u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (load_val),
    .tens     (tens),
    .units    (units),
    .is_one   (is_one)
  );

  assign phase = state_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: doc/wash_countdown.md
WASH_COUNTDOWN -- requirements
Module: wash_countdown

Interface
REQ-001 The block SHALL have the parameter TICK_DIV, default 100000000, giving clk cycles per 1 s countdown tick (range 2..2^32-1).
REQ-002 The block SHALL have the parameter WASH_S, default 30, giving the WASH phase duration in seconds (range 1..99).
REQ-003 The block SHALL have the parameter RINSE_S, default 20, giving the RINSE phase duration in seconds (range 1..99).
REQ-004 The block SHALL have the parameter SPIN_S, default 15, giving the SPIN phase duration in seconds (range 1..99).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit, synchronous to clk: start request, acted on at its rising edge.
REQ-008 The block SHALL have port pause, input, 1 bit, level: freezes the countdown while high.
REQ-009 The block SHALL have port tens, output, 4 bits: BCD tens digit of the remaining seconds, feeding display digit p1.
REQ-010 The block SHALL have port units, output, 4 bits: BCD units digit of the remaining seconds, feeding display digit p2.
REQ-011 The block SHALL have port phase, output, 3 bits: current state code.
REQ-012 The block SHALL have port busy, output, 1 bit: high in WASH, RINSE and SPIN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the program finishes.

Function
REQ-014 All outputs SHALL be registered; the state machine SHALL have the states IDLE=0, WASH=1, RINSE=2, SPIN=3 and DONE=4, and phase SHALL equal the state code.
REQ-015 A start rising edge SHALL be detected by comparing start with a registered copy of start; a start rising edge in IDLE or DONE SHALL enter WASH on the next edge, loading tens/units with the BCD of WASH_S and clearing the prescaler.
REQ-016 A start rising edge in WASH, RINSE or SPIN SHALL be ignored.
REQ-017 The prescaler SHALL run only in WASH, RINSE and SPIN while pause=0, counting 0..TICK_DIV-1; the tick SHALL assert in the cycle the count equals TICK_DIV-1, and the count SHALL then wrap to 0.
REQ-018 On a tick with remaining value > 1, the counter SHALL decrement in BCD: if units≠0 then units-1, else units=9 and tens-1 (e.g. 10 -> 09).
REQ-019 On a tick with remaining value == 01, WASH SHALL go to RINSE (load RINSE_S), RINSE SHALL go to SPIN (load SPIN_S), and SPIN SHALL go to DONE (load 00).
REQ-020 On entry to DONE, done SHALL be high for exactly one cycle; DONE SHALL hold 00 until a start rising edge.
REQ-021 While pause=1, the prescaler, tens, units and state SHALL hold their values; on release, counting SHALL resume from the retained prescaler value.
REQ-022 A start rising edge in IDLE with pause=1 SHALL still enter WASH and load WASH_S, holding there until pause falls.
REQ-023 busy SHALL be high in WASH, RINSE and SPIN and low otherwise.
REQ-024 A program SHALL take exactly TICK_DIV*(WASH_S+RINSE_S+SPIN_S) unpaused cycles from WASH entry to DONE entry.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, tens=0, units=0, phase=0, busy=0, done=0, prescaler=0 and the start history register=0, and SHALL take priority over start, pause and tick.
REQ-026 rst asserted mid-program SHALL abandon the program with no done pulse; rst falling SHALL leave the block in IDLE awaiting a start edge.

Structure
REQ-027 The state codes, the default durations and a binary-to-2-digit-BCD constant function SHALL reside in a shared definitions file also used by the display path.
REQ-028 The two-digit BCD load/decrement register SHALL be one sub-module named bcd2_down_counter, with load, dec, a load value, tens/units outputs and an is_one flag.

Verification
REQ-029 The bench SHALL use TICK_DIV=4, WASH_S=3, RINSE_S=2 and SPIN_S=2 unless a scenario states otherwise.
REQ-030 Scenario, reset: assert rst for 2 cycles -> tens=0, units=0, phase=0, busy=0, done=0.
REQ-031 Scenario, start: one-cycle start pulse -> next cycle phase=1, 03, busy=1; 4 cycles later 02; a start pulse during WASH leaves the state unchanged.
REQ-032 Scenario, borrow: WASH_S=10 -> after first tick 09, tens=0, units=9.
REQ-033 Scenario, pause: hold pause=1 for 10 cycles mid-WASH -> tens, units, phase and prescaler unchanged; after release, the tick occurs after the remaining prescaler cycles.
REQ-034 Scenario, full run: no pause -> phase sequence 1, 2, 3, 4; done high exactly 1 cycle, 28 cycles after WASH entry; DONE shows 00, busy=0; a new start reloads 03.
REQ-035 Scenario, reset mid-run: rst during SPIN -> IDLE with 00 next cycle and no done pulse.
